// File: rtl/chacha20_poly1305_tag_verify.sv
// Constant-time Poly1305 tag checker: collects the received tag and the computed tag,
// then OR-folds their XOR over exactly four word cycles regardless of data.
module chacha20_poly1305_tag_verify (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         exp_we,
  input  logic [1:0]   exp_addr,
  input  logic [31:0]  exp_word,
  input  logic         calc_valid,
  input  logic [127:0] calc_tag,
  output logic         ready,
  output logic         done,
  output logic         tag_correct
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    mask_q, mask_d;
  logic          calc_loaded_q, calc_loaded_d;
  logic [31:0]   diff_q, diff_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   exp_q [4];
  logic [31:0]   exp_d [4];
  logic [127:0]  calc_q, calc_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          tag_correct_q, tag_correct_d;
  logic [31:0]   calc_word_s;

  // Word 0 of the computed tag is its most significant 32 bits, matching exp_addr 0.
  always_comb begin
    case (cnt_q)
      2'd0:    calc_word_s = calc_q[127:96];
      2'd1:    calc_word_s = calc_q[95:64];
      2'd2:    calc_word_s = calc_q[63:32];
      2'd3:    calc_word_s = calc_q[31:0];
      default: calc_word_s = 32'd0;
    endcase
  end

  // Next-state and datapath updates; init overrides everything else.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    calc_loaded_d = calc_loaded_q;
    diff_d        = diff_q;
    cnt_d         = cnt_q;
    exp_d         = exp_q;
    calc_d        = calc_q;
    done_d        = done_q;
    tag_correct_d = tag_correct_q;

    if (init) begin
      state_d       = COLLECT;
      mask_d        = 4'h0;
      calc_loaded_d = 1'b0;
      diff_d        = 32'd0;
      cnt_d         = 2'd0;
      done_d        = 1'b0;
      tag_correct_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        COLLECT: begin
          if (exp_we) begin
            exp_d[exp_addr]  = exp_word;
            mask_d[exp_addr] = 1'b1;
          end else begin
            mask_d = mask_q;
          end
          if (calc_valid) begin
            calc_d        = calc_tag;
            calc_loaded_d = 1'b1;
          end else begin
            calc_loaded_d = calc_loaded_q;
          end
          if ((mask_q == 4'hf) && calc_loaded_q) begin
            state_d = COMPARE;
            cnt_d   = 2'd0;
          end else begin
            state_d = COLLECT;
          end
        end
        COMPARE: begin
          // No early exit: every word is folded in even after a mismatch.
          diff_d = diff_q | (exp_q[cnt_q] ^ calc_word_s);
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d       = DONE;
            done_d        = 1'b1;
            tag_correct_d = (diff_d == 32'd0);
          end else begin
            state_d = COMPARE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    ready_d = (state_d == IDLE) || (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mask_q        <= 4'h0;
      calc_loaded_q <= 1'b0;
      diff_q        <= 32'd0;
      cnt_q         <= 2'd0;
      exp_q[0]      <= 32'd0;
      exp_q[1]      <= 32'd0;
      exp_q[2]      <= 32'd0;
      exp_q[3]      <= 32'd0;
      calc_q        <= 128'd0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      tag_correct_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      calc_loaded_q <= calc_loaded_d;
      diff_q        <= diff_d;
      cnt_q         <= cnt_d;
      exp_q         <= exp_d;
      calc_q        <= calc_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      tag_correct_q <= tag_correct_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign tag_correct = tag_correct_q;

endmodule
